// File: rtl/t_table_pkg.sv
// Shared types and helpers for the cumulative autocorrelation table server.
package t_table_pkg;

    localparam int T_BW      = 32;
    localparam int NU_VALUES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } t_state_t;

    typedef struct packed {
        logic [T_BW-1:0] sum;
        logic            ovf;
    } sat_res_t;

    // Signed add with one guard bit, clamped to the representable range.
    function automatic sat_res_t sat_add(input logic [T_BW-1:0] a, input logic [T_BW-1:0] b);
        logic [T_BW:0] wide_s;
        sat_res_t      res_s;
        wide_s = {a[T_BW-1], a} + {b[T_BW-1], b};
        if (wide_s[T_BW] != wide_s[T_BW-1]) begin
            res_s.ovf = 1'b1;
            if (wide_s[T_BW]) begin
                res_s.sum = {1'b1, {(T_BW-1){1'b0}}};
            end else begin
                res_s.sum = {1'b0, {(T_BW-1){1'b1}}};
            end
        end else begin
            res_s.ovf = 1'b0;
            res_s.sum = wide_s[T_BW-1:0];
        end
        return res_s;
    endfunction

endpackage

// File: rtl/t_table_server_lane.sv
// One lag lane of the table: simple dual-port memory with registered read
// address and a registered, zero-forcible read output.
module t_lane_bram #(
    parameter int W  = 32,
    parameter int D  = 160,
    parameter int AW = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_zero,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0]  mem_r [D];
    logic [AW-1:0] rd_addr_r;
    logic [W-1:0]  rd_data_r;

    // Write port: contents survive reset and clear by design.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read pipeline: address register, then output register; a same-cycle write returns old data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_addr_r <= {AW{1'b0}};
            rd_data_r <= {W{1'b0}};
        end else begin
            rd_addr_r <= rd_addr;
            rd_data_r <= rd_zero ? {W{1'b0}} : mem_r[rd_addr_r];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/t_table_server.sv
// Builds the running sums T(k,nu) of incoming lag frames into three lane
// memories and serves indexed reads at a fixed two-cycle latency.
module t_table_server
    import t_table_pkg::*;
#(
    parameter int BIT_WIDTH = T_BW,
    parameter int I         = 160,
    localparam int IW       = $clog2(I)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clear_in,
    input  logic                 frame_valid,
    input  logic                 frame_last,
    input  logic [BIT_WIDTH-1:0] r0_in,
    input  logic [BIT_WIDTH-1:0] r1_in,
    input  logic [BIT_WIDTH-1:0] r2_in,
    output logic                 frame_ready,
    output logic                 table_valid,
    output logic [IW:0]          count,
    output logic                 sat_flag,
    input  logic [IW-1:0]        T_req,
    output logic [BIT_WIDTH-1:0] T_resp0,
    output logic [BIT_WIDTH-1:0] T_resp1,
    output logic [BIT_WIDTH-1:0] T_resp2
);

    localparam logic [IW:0] COUNT_MAX = (IW+1)'(I);
    localparam logic [IW:0] COUNT_ONE = (IW+1)'(1);

    t_state_t                                state_r, state_s;
    logic [IW:0]                             count_r, count_s;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0]     acc_r, acc_s, r_s, resp_s;
    logic                                    sat_r, sat_s;
    logic                                    frame_ready_r, table_valid_r;
    logic                                    wr_en_s;
    logic                                    in_range_r;
    sat_res_t                                lane_res_s [NU_VALUES];

    assign r_s = {r2_in, r1_in, r0_in};

    // Next-state, accumulator update and write strobe; clear overrides everything.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        acc_s   = acc_r;
        sat_s   = sat_r;
        wr_en_s = 1'b0;
        for (int n = 0; n < NU_VALUES; n++) begin
            lane_res_s[n] = sat_add(acc_r[n], r_s[n]);
        end
        if (clear_in) begin
            state_s = IDLE;
            count_s = {(IW+1){1'b0}};
            acc_s   = '0;
            sat_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = BUILD;
                end
                BUILD: begin
                    if (frame_valid && frame_ready_r) begin
                        wr_en_s = 1'b1;
                        count_s = count_r + COUNT_ONE;
                        for (int n = 0; n < NU_VALUES; n++) begin
                            acc_s[n] = lane_res_s[n].sum;
                        end
                        sat_s = sat_r | lane_res_s[0].ovf | lane_res_s[1].ovf | lane_res_s[2].ovf;
                        if (frame_last || (count_s == COUNT_MAX)) begin
                            state_s = DONE;
                        end else begin
                            state_s = BUILD;
                        end
                    end else begin
                        state_s = BUILD;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, build counters and status outputs; status is derived from the next state so it tracks the FSM without lag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r       <= IDLE;
            count_r       <= {(IW+1){1'b0}};
            acc_r         <= '0;
            sat_r         <= 1'b0;
            frame_ready_r <= 1'b0;
            table_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            acc_r         <= acc_s;
            sat_r         <= sat_s;
            frame_ready_r <= (state_s == BUILD);
            table_valid_r <= (state_s == DONE);
        end
    end

    // Range check travels with the read address; the lane output register applies it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            in_range_r <= 1'b0;
        end else begin
            in_range_r <= ({1'b0, T_req} < count_r);
        end
    end

    for (genvar g = 0; g < NU_VALUES; g++) begin : g_lane
        t_lane_bram #(
            .W  (BIT_WIDTH),
            .D  (I),
            .AW (IW)
        ) u_lane (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .wr_en   (wr_en_s),
            .wr_addr (count_r[IW-1:0]),
            .wr_data (acc_s[g]),
            .rd_addr (T_req),
            .rd_zero (~in_range_r),
            .rd_data (resp_s[g])
        );
    end

    assign frame_ready = frame_ready_r;
    assign table_valid = table_valid_r;
    assign count       = count_r;
    assign sat_flag    = sat_r;
    assign T_resp0     = resp_s[0];
    assign T_resp1     = resp_s[1];
    assign T_resp2     = resp_s[2];

endmodule

// File: tb/tb_t_table_server.sv
// Self-checking bench for t_table_server: directed scenarios with literal
// expectations plus randomized traffic against a behavioural table model.
module tb_t_table_server;

    localparam int I  = 160;
    localparam int IW = 8;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          clear_in = 1'b0;
    logic          frame_valid = 1'b0;
    logic          frame_last = 1'b0;
    logic [31:0]   r0_in = 32'd0, r1_in = 32'd0, r2_in = 32'd0;
    logic          frame_ready, table_valid, sat_flag;
    logic [IW:0]   count;
    logic [IW-1:0] T_req = 8'd0;
    logic [31:0]   T_resp0, T_resp1, T_resp2;

    int n_total = 0;
    int n_pass  = 0;

    // behavioural model: phase 0 idle, 1 building, 2 done
    int     m_phase = 0;
    int     m_count = 0;
    bit     m_sat = 1'b0;
    longint m_acc [3];
    longint m_tab [256][3];
    longint m_p1 [3];
    longint m_p2 [3];

    t_table_server dut (
        .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
        .frame_valid(frame_valid), .frame_last(frame_last),
        .r0_in(r0_in), .r1_in(r1_in), .r2_in(r2_in),
        .frame_ready(frame_ready), .table_valid(table_valid),
        .count(count), .sat_flag(sat_flag), .T_req(T_req),
        .T_resp0(T_resp0), .T_resp1(T_resp1), .T_resp2(T_resp2)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic longint lane_in(input int l);
        if (l == 0) return longint'($signed(r0_in));
        else if (l == 1) return longint'($signed(r1_in));
        else return longint'($signed(r2_in));
    endfunction

    // model: cumulative sums with clamping, read answers two cycles late
    initial begin
        for (int l = 0; l < 3; l++) begin m_acc[l] = 0; m_p1[l] = 0; m_p2[l] = 0; end
        forever begin
            @(posedge clk_in or posedge rst_in);
            if (rst_in) begin
                m_phase = 0; m_count = 0; m_sat = 1'b0;
                for (int l = 0; l < 3; l++) begin m_acc[l] = 0; m_p1[l] = 0; m_p2[l] = 0; end
            end else begin
                for (int l = 0; l < 3; l++) begin
                    m_p2[l] = m_p1[l];
                    m_p1[l] = (int'(T_req) < m_count) ? m_tab[T_req][l] : 0;
                end
                if (clear_in) begin
                    m_phase = 0; m_count = 0; m_sat = 1'b0;
                    for (int l = 0; l < 3; l++) m_acc[l] = 0;
                end else if (m_phase == 0) begin
                    m_phase = 1;
                end else if (m_phase == 1 && frame_valid) begin
                    for (int l = 0; l < 3; l++) begin
                        longint s;
                        s = m_acc[l] + lane_in(l);
                        if (s > MAXV) begin s = MAXV; m_sat = 1'b1; end
                        if (s < MINV) begin s = MINV; m_sat = 1'b1; end
                        m_acc[l] = s;
                        m_tab[m_count][l] = s;
                    end
                    m_count++;
                    if (frame_last || m_count == I) m_phase = 2;
                end
            end
        end
    end

    // compare process: every cycle, all outputs against the model
    initial begin
        forever begin
            @(negedge clk_in);
            chk("frame_ready", {31'd0, frame_ready}, {31'd0, m_phase == 1});
            chk("table_valid", {31'd0, table_valid}, {31'd0, m_phase == 2});
            chk("count", {23'd0, count}, 32'(m_count));
            chk("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
            chk("T_resp0", T_resp0, m_p2[0][31:0]);
            chk("T_resp1", T_resp1, m_p2[1][31:0]);
            chk("T_resp2", T_resp2, m_p2[2][31:0]);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic last);
        int n;
        frame_valid = 1'b1; frame_last = last;
        r0_in = a; r1_in = b; r2_in = c;
        n = 0;
        while (!frame_ready && n < 50) begin tick(); n++; end
        chk("frame_ready_wait", 32'(n < 50), 32'd1);
        tick();
        frame_valid = 1'b0; frame_last = 1'b0;
    endtask

    task automatic read1(input string nm, input logic [IW-1:0] idx,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        T_req = idx;
        tick();
        tick();
        chk({nm, "_l0"}, T_resp0, e0);
        chk({nm, "_l1"}, T_resp1, e1);
        chk({nm, "_l2"}, T_resp2, e2);
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] reqs [4];
        logic [31:0]   exp0 [4];
        logic [31:0]   exp1 [4];
        logic [31:0]   exp2 [4];

        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_count", {23'd0, count}, 32'd0);
        chk("reset_ready", {31'd0, frame_ready}, 32'd0);
        chk("reset_resp0", T_resp0, 32'd0);
        rst_in = 1'b0;

        // 1: four-frame build
        send_frame(32'd10, 32'd3, -32'sd1, 1'b0);
        send_frame(32'd20, -32'sd5, 32'd2, 1'b0);
        send_frame(-32'sd7, 32'd1, 32'd1, 1'b0);
        send_frame(32'd0, 32'd0, 32'd0, 1'b1);
        chk("t1_count", {23'd0, count}, 32'd4);
        chk("t1_table_valid", {31'd0, table_valid}, 32'd1);
        chk("t1_ready_low", {31'd0, frame_ready}, 32'd0);
        read1("t1_T0", 8'd0, 32'd10, 32'd3, 32'hFFFF_FFFF);
        read1("t1_T1", 8'd1, 32'd30, 32'hFFFF_FFFE, 32'd1);
        read1("t1_T2", 8'd2, 32'd23, 32'hFFFF_FFFF, 32'd2);
        read1("t1_T3", 8'd3, 32'd23, 32'hFFFF_FFFF, 32'd2);

        // 2: back-to-back reads, including one past count
        reqs = '{8'd3, 8'd0, 8'd2, 8'd9};
        exp0 = '{32'd23, 32'd10, 32'd23, 32'd0};
        exp1 = '{32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd0};
        exp2 = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'd0};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) T_req = reqs[i];
            if (i >= 2) begin
                chk("t2_l0", T_resp0, exp0[i-2]);
                chk("t2_l1", T_resp1, exp1[i-2]);
                chk("t2_l2", T_resp2, exp2[i-2]);
            end
            tick();
        end

        // 3: fill to depth without frame_last
        do_clear();
        for (int i = 0; i < I; i++) send_frame(32'd1, 32'd1, 32'd1, 1'b0);
        chk("t3_count", {23'd0, count}, 32'd160);
        chk("t3_ready_low", {31'd0, frame_ready}, 32'd0);
        chk("t3_table_valid", {31'd0, table_valid}, 32'd1);
        frame_valid = 1'b1;
        repeat (3) tick();
        frame_valid = 1'b0;
        chk("t3_ignored", {23'd0, count}, 32'd160);
        read1("t3_T159", 8'd159, 32'd160, 32'd160, 32'd160);

        // 4: saturation in both directions
        do_clear();
        send_frame(32'h7FFF_FF00, 32'h8000_0100, 32'd5, 1'b0);
        send_frame(32'h7FFF_FF00, 32'h8000_0100, 32'd5, 1'b1);
        chk("t4_sat_flag", {31'd0, sat_flag}, 32'd1);
        read1("t4_T0", 8'd0, 32'h7FFF_FF00, 32'h8000_0100, 32'd5);
        read1("t4_T1", 8'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd10);

        // 5: asynchronous reset mid-build, then short rebuild
        do_clear();
        for (int i = 0; i < 5; i++) send_frame(32'(i + 1), 32'd2, 32'd3, 1'b0);
        chk("t5_count5", {23'd0, count}, 32'd5);
        T_req = 8'd1;
        tick();
        #2;
        rst_in = 1'b1;
        #1;
        chk("t5_rst_count", {23'd0, count}, 32'd0);
        chk("t5_rst_ready", {31'd0, frame_ready}, 32'd0);
        chk("t5_rst_resp0", T_resp0, 32'd0);
        chk("t5_rst_resp1", T_resp1, 32'd0);
        chk("t5_rst_resp2", T_resp2, 32'd0);
        tick();
        rst_in = 1'b0;
        send_frame(32'd4, 32'd5, 32'd6, 1'b0);
        send_frame(32'd1, 32'd1, 32'd1, 1'b1);
        chk("t5_count2", {23'd0, count}, 32'd2);
        read1("t5_idx4", 8'd4, 32'd0, 32'd0, 32'd0);
        read1("t5_idx1", 8'd1, 32'd5, 32'd6, 32'd7);

        // 6: clear in DONE with a frame already waiting
        frame_valid = 1'b1; frame_last = 1'b1;
        r0_in = 32'd7; r1_in = 32'd8; r2_in = 32'd9;
        do_clear();
        chk("t6_tv_low", {31'd0, table_valid}, 32'd0);
        chk("t6_count0", {23'd0, count}, 32'd0);
        tick();
        tick();
        frame_valid = 1'b0; frame_last = 1'b0;
        chk("t6_count1", {23'd0, count}, 32'd1);
        chk("t6_tv_high", {31'd0, table_valid}, 32'd1);
        read1("t6_T0", 8'd0, 32'd7, 32'd8, 32'd9);

        // randomized traffic, checked by the compare process
        for (int c = 0; c < 5000; c++) begin
            frame_valid = ($urandom_range(0, 3) != 0);
            frame_last  = ($urandom_range(0, 40) == 0);
            clear_in    = ($urandom_range(0, 250) == 0);
            if ($urandom_range(0, 1) == 0) begin
                r0_in = 32'($signed($urandom_range(0, 400)) - 200);
                r1_in = 32'($signed($urandom_range(0, 400)) - 200);
                r2_in = 32'($signed($urandom_range(0, 400)) - 200);
            end else begin
                r0_in = $urandom(); r1_in = $urandom(); r2_in = $urandom();
            end
            if (m_count > 0 && $urandom_range(0, 3) != 0) T_req = IW'($urandom_range(0, m_count - 1));
            else T_req = IW'($urandom_range(0, 255));
            tick();
        end
        clear_in = 1'b0; frame_valid = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
